// File: rtl/text_layer_pkg.sv
// Shared definitions for the character-cell text renderer.
// Optional feature macro used by this slice: TEXT_LAYER_CURSOR_EN.
package text_layer_pkg;

    localparam logic [7:0]  CLEAR_CODE = 8'h20;
    localparam int unsigned BLINK_BIT  = 4;

    // Number of address bits needed to index v entries.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Cell address width for the default 80 x 30 geometry.
    localparam int unsigned CELL_ADDR_W = clog2(80 * 30);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/text_layer_renderer_ram.sv
// Text buffer: simple dual-port single-clock RAM with a registered,
// read-first read port.
// Ports: clk, rst_n (sync, clears read data only), wr_en/wr_addr/wr_data
// write port, rd_en/rd_addr read request, rd_data registered read data.
module text_buffer_ram #(
    parameter int unsigned DEPTH  = 2400,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is initialised by the owner's clear sweep, so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read alongside the write gives old data on a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/text_layer_renderer.sv
// Character-cell text layer: maps each raster pixel to a text cell and a
// glyph offset, fetches the cell's code, queries the external font ROM and
// emits a 1-bit pixel two cycles after the raster strobe.
// Ports: clk, rst_n (sync active-low); in_valid/in_x/in_y raster input;
// wr_en/wr_col/wr_row/wr_code host buffer write; busy while clearing;
// sym_x/sym_y/sym_code to font ROM, sym_pixel same-cycle ROM response;
// out_valid/out_pixel rendered output.
// Optional: define TEXT_LAYER_CURSOR_EN to add cursor_col/cursor_row and a
// blinking inverted cursor cell.
module text_layer_renderer #(
    parameter int unsigned XY_BIT_DEPTH = 8,
    parameter int unsigned PIX_W        = 10,
    parameter int unsigned GLYPH_W      = 8,
    parameter int unsigned GLYPH_H      = 16,
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter logic [7:0]  CLEAR_CODE   = 8'h20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [PIX_W-1:0]        in_x,
    input  logic [PIX_W-1:0]        in_y,
    input  logic                    wr_en,
    input  logic [6:0]              wr_col,
    input  logic [4:0]              wr_row,
    input  logic [7:0]              wr_code,
    output logic                    busy,
    output logic [XY_BIT_DEPTH-1:0] sym_x,
    output logic [XY_BIT_DEPTH-1:0] sym_y,
    output logic [7:0]              sym_code,
    input  logic                    sym_pixel,
    output logic                    out_valid,
    output logic                    out_pixel
`ifdef TEXT_LAYER_CURSOR_EN
    ,
    input  logic [6:0]              cursor_col,
    input  logic [4:0]              cursor_row
`endif
);

    import text_layer_pkg::*;

    localparam int unsigned GX_W   = clog2(GLYPH_W);
    localparam int unsigned GY_W   = clog2(GLYPH_H);
    localparam int unsigned DEPTH  = COLS * ROWS;
    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam int unsigned COL_W  = PIX_W - GX_W;
    localparam int unsigned ROW_W  = PIX_W - GY_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clear_addr;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    logic              wr_ok;
    logic [ADDR_W-1:0] wr_addr;

    logic [COL_W-1:0]  cell_col;
    logic [ROW_W-1:0]  cell_row;
    logic              in_range;
    logic [ADDR_W-1:0] rd_addr;
    logic              cursor_hit;

    logic              s1_valid;
    logic              s1_in_range;
    logic              s1_clearing;
    logic              s1_invert;

    // Host write address decode; out-of-grid writes are dropped.
    assign wr_ok   = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
    assign wr_addr = ADDR_W'(ADDR_W'(wr_row) * ADDR_W'(COLS) + ADDR_W'(wr_col));

    // Stage 0: pixel coordinate to cell; off-grid cells read address 0.
    assign cell_col = in_x[PIX_W-1:GX_W];
    assign cell_row = in_y[PIX_W-1:GY_W];
    assign in_range = (32'(cell_col) < COLS) && (32'(cell_row) < ROWS);
    assign rd_addr  = in_range
                    ? ADDR_W'(ADDR_W'(cell_row) * ADDR_W'(COLS) + ADDR_W'(cell_col))
                    : '0;

`ifdef TEXT_LAYER_CURSOR_EN
    localparam int unsigned FC_W = BLINK_BIT + 1;
    logic [FC_W-1:0] frame_cnt;

    // Frame counter: the (0,0) pixel marks the start of each frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (in_valid && (in_x == '0) && (in_y == '0)) begin
            frame_cnt <= frame_cnt + FC_W'(1);
        end
    end

    // Cursor shown in the first half of each 32-frame period.
    assign cursor_hit = !frame_cnt[BLINK_BIT]
                      && (32'(cursor_col) < COLS) && (32'(cursor_row) < ROWS)
                      && (32'(cell_col) == 32'(cursor_col))
                      && (32'(cell_row) == 32'(cursor_row));
`else
    assign cursor_hit = 1'b0;
`endif

    // FSM state register, plus sweep address and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clear_addr <= '0;
            busy       <= 1'b1;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clear_addr <= clear_addr + ADDR_W'(1);
            end
            busy <= (state_next == CLEAR);
        end
    end

    // Next state: leave CLEAR after the last cell has been written.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clear_addr == LAST_ADDR) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    // Write port owner: the clear sweep in CLEAR, the host in RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        case (state)
            CLEAR: begin
                ram_we    = rst_n;
                ram_waddr = clear_addr;
                ram_wdata = CLEAR_CODE;
            end
            RUN: begin
                ram_we    = rst_n && wr_en && wr_ok;
                ram_waddr = wr_addr;
                ram_wdata = wr_code;
            end
            default: ;
        endcase
    end

    // Read data register doubles as the sym_code output.
    text_buffer_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (8),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (in_valid),
        .rd_addr (rd_addr),
        .rd_data (sym_code)
    );

    // Stage 1 registers and final pixel; sym_* hold while the raster idles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_clearing <= 1'b0;
            s1_invert   <= 1'b0;
            sym_x       <= '0;
            sym_y       <= '0;
            out_valid   <= 1'b0;
            out_pixel   <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                sym_x       <= XY_BIT_DEPTH'(in_x[GX_W-1:0]);
                sym_y       <= XY_BIT_DEPTH'(in_y[GY_W-1:0]);
                s1_in_range <= in_range;
                s1_clearing <= (state == CLEAR);
                s1_invert   <= cursor_hit;
            end
            out_valid <= s1_valid;
            out_pixel <= s1_valid && s1_in_range && !s1_clearing && (sym_pixel ^ s1_invert);
        end
    end

endmodule

// File: tb/tb_text_layer_renderer.sv
// Scoreboard bench for text_layer_renderer: a driver applies stimulus and
// queues expected font queries and pixels from a cell-array reference model;
// a monitor on the falling edge pops and compares them.
// Honours TEXT_LAYER_CURSOR_EN when defined.
module tb_text_layer_renderer;

    localparam int NCOLS = 80;
    localparam int NROWS = 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [9:0] in_x, in_y;
    logic       wr_en;
    logic [6:0] wr_col;
    logic [4:0] wr_row;
    logic [7:0] wr_code;
    logic       busy;
    logic [7:0] sym_x, sym_y, sym_code;
    logic       sym_pixel;
    logic       out_valid, out_pixel;
`ifdef TEXT_LAYER_CURSOR_EN
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
`endif

    always #5 clk = ~clk;

    text_layer_renderer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .wr_en     (wr_en),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_code   (wr_code),
        .busy      (busy),
        .sym_x     (sym_x),
        .sym_y     (sym_y),
        .sym_code  (sym_code),
        .sym_pixel (sym_pixel),
        .out_valid (out_valid),
        .out_pixel (out_pixel)
`ifdef TEXT_LAYER_CURSOR_EN
        ,
        .cursor_col(cursor_col),
        .cursor_row(cursor_row)
`endif
    );

    // Font ROM stand-in: arbitrary but deterministic glyph bits.
    logic rom_force;
    function automatic logic font_bit(input logic [7:0] code, input logic [2:0] gx,
                                      input logic [3:0] gy);
        int h;
        h = int'(code) * 31 + int'(gx) * 7 + int'(gy) * 13;
        return h[2] ^ code[gx];
    endfunction
    assign sym_pixel = rom_force | font_bit(sym_code, sym_x[2:0], sym_y[3:0]);

    typedef struct { int due; logic pix; } pix_t;
    typedef struct { int due; logic [7:0] code; logic [7:0] gx; logic [7:0] gy; } sym_t;

    pix_t       pixq[$];
    sym_t       symq[$];
    logic [7:0] cells [NCOLS*NROWS];
    int         clear_left;
    int         frame_cnt;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; expectations come from the cell-array model.
    task automatic step(input bit v, input int x, input int y, input bit we,
                        input int c, input int r, input int code);
        int   col, row, gx, gy;
        bit   inr, clr, inv;
        logic [7:0] old;
        pix_t p;
        sym_t s;
        check("busy", 32'(busy), 32'(clear_left > 0));
        in_valid = v;
        in_x     = 10'(x);
        in_y     = 10'(y);
        wr_en    = we;
        wr_col   = 7'(c);
        wr_row   = 5'(r);
        wr_code  = 8'(code);
        if (v) begin
            col = x / 8;
            row = y / 16;
            gx  = x % 8;
            gy  = y % 16;
            inr = (col < NCOLS) && (row < NROWS);
            clr = (clear_left > 0);
            old = inr ? cells[row*NCOLS + col] : 8'h00;
            inv = 1'b0;
`ifdef TEXT_LAYER_CURSOR_EN
            inv = ((frame_cnt % 32) < 16) && (col == int'(cursor_col)) && (row == int'(cursor_row))
                  && (int'(cursor_col) < NCOLS) && (int'(cursor_row) < NROWS);
`endif
            p.due = cyc + 2;
            p.pix = inr && !clr && ((rom_force | font_bit(old, 3'(gx), 4'(gy))) ^ inv);
            pixq.push_back(p);
            if (inr && !clr) begin
                s.due  = cyc + 1;
                s.code = old;
                s.gx   = 8'(gx);
                s.gy   = 8'(gy);
                symq.push_back(s);
            end
            if (x == 0 && y == 0) frame_cnt++;
        end
        if (we && clear_left == 0 && c < NCOLS && r < NROWS) cells[r*NCOLS + c] = 8'(code);
        @(posedge clk);
        #1;
        if (clear_left > 0) clear_left--;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic rand_step();
        int sel, x, y, c, r;
        sel = int'($urandom_range(9));
        if (sel == 0) begin
            x = 0; y = 0;
        end else if (sel <= 5) begin
            x = int'($urandom_range(63)); y = int'($urandom_range(63));
        end else begin
            x = int'($urandom_range(719)); y = int'($urandom_range(527));
        end
        if (sel <= 5) begin
            c = int'($urandom_range(9)); r = int'($urandom_range(3));
        end else begin
            c = int'($urandom_range(84)); r = int'($urandom_range(31));
        end
        step($urandom_range(3) != 0, x, y, $urandom_range(3) == 0, c, r,
             int'($urandom_range(255)));
    endtask

    // Drain the pipeline, pulse reset for one clock, then re-arm the model.
    task automatic do_reset();
        repeat (3) idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pixel", 32'(out_pixel), 32'd0);
        check("rst_sym", {sym_code, sym_x, sym_y}, 32'd0);
        clear_left = NCOLS * NROWS;
        frame_cnt  = 0;
        for (int i = 0; i < NCOLS*NROWS; i++) cells[i] = 8'h20;
    endtask

    // Monitor: font queries one cycle after input, pixels two cycles after.
    always @(negedge clk) begin
        pix_t p;
        sym_t s;
        if (symq.size() > 0 && symq[0].due <= cyc) begin
            s = symq.pop_front();
            check("sym_due", 32'(cyc), 32'(s.due));
            check("sym_code", 32'(sym_code), 32'(s.code));
            check("sym_x", 32'(sym_x), 32'(s.gx));
            check("sym_y", 32'(sym_y), 32'(s.gy));
        end
        if (out_valid === 1'b1) begin
            if (pixq.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                p = pixq.pop_front();
                check("pixel_due", 32'(cyc), 32'(p.due));
                check("out_pixel", 32'(out_pixel), 32'(p.pix));
            end
        end else begin
            check("idle_pixel", 32'(out_pixel), 32'd0);
            if (pixq.size() > 0 && pixq[0].due <= cyc) begin
                void'(pixq.pop_front());
                check("out_valid", 32'(out_valid), 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        wr_en     = 1'b0;
        wr_col    = '0;
        wr_row    = '0;
        wr_code   = '0;
        rom_force = 1'b0;
        frame_cnt = 0;
`ifdef TEXT_LAYER_CURSOR_EN
        cursor_col = 7'd1;
        cursor_row = 5'd1;
`endif
        clear_left = 1 << 30;
        @(posedge clk);
        #1;
        do_reset();

        // Sweep interrupted at address 1000 with random raster traffic.
        repeat (997) rand_step();
        do_reset();

        // Full sweep; the write at step 10 must be dropped.
        for (int k = 0; k < NCOLS*NROWS + 4; k++) begin
            if (k == 10)
                step(1'b1, 45, 85, 1'b1, 5, 5, 8'h7F);
            else if (k % 7 == 0)
                step(1'b1, int'($urandom_range(639)), int'($urandom_range(479)), 1'b0, 0, 0, 0);
            else
                idle();
        end

        // Every cell holds the clear code.
        for (int r = 0; r < NROWS; r++)
            for (int c = 0; c < NCOLS; c++)
                step(1'b1, c*8 + int'($urandom_range(7)), r*16 + int'($urandom_range(15)),
                     1'b0, 0, 0, 0);

        // Glyph 'A' in cell (0,0).
        step(1'b0, 0, 0, 1'b1, 0, 0, 8'h41);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++)
                step(1'b1, x, y, 1'b0, 0, 0, 0);

        // ROM stuck high: off-grid pixels stay 0, on-grid pixel is 1.
        repeat (3) idle();
        rom_force = 1'b1;
        step(1'b1, 640, 0, 1'b0, 0, 0, 0);
        step(1'b1, 700, 479, 1'b0, 0, 0, 0);
        step(1'b1, 0, 480, 1'b0, 0, 0, 0);
        step(1'b1, 20, 40, 1'b0, 0, 0, 0);
        repeat (3) idle();
        rom_force = 1'b0;

        // Same-cycle write and read of cell (3,2): old code, then new.
        step(1'b1, 26, 37, 1'b1, 3, 2, 8'h42);
        step(1'b1, 26, 37, 1'b0, 0, 0, 0);

        repeat (3000) rand_step();
        repeat (4) idle();
        check("queues_drained", 32'(pixq.size() + symq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/text_layer_renderer.md
Name: text_layer_renderer

Overview:
- Character-cell text renderer; drives the font ROM lookup interface (sym_x, sym_y, sym_code out; sym_pixel in) from a raster pixel stream.
- Holds a COLS x ROWS text buffer written by a host port; maps each incoming pixel coordinate to a cell and a glyph offset, fetches the code, queries the font, emits a 1-bit pixel.
- Sits between the video timing generator and the colour mux; the font ROM wrapper is instantiated beside it, combinational, same-cycle response.

Parameters:
- XY_BIT_DEPTH, 8, width of sym_x/sym_y (matches font ROM wrapper)
- PIX_W, 10, width of raster x/y coordinates
- GLYPH_W, 8, glyph width in pixels, power of 2
- GLYPH_H, 16, glyph height in pixels, power of 2
- COLS, 80, text columns
- ROWS, 30, text rows
- CLEAR_CODE, 8'h20, code written to every cell by the clear sweep

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  raster pixel strobe
- in_x  in  PIX_W  raster x
- in_y  in  PIX_W  raster y
- wr_en  in  1  text buffer write strobe
- wr_col  in  7  write column
- wr_row  in  5  write row
- wr_code  in  8  character code
- busy  out  1  clear sweep in progress
- sym_x  out  XY_BIT_DEPTH  glyph column to font ROM
- sym_y  out  XY_BIT_DEPTH  glyph row to font ROM
- sym_code  out  8  code to font ROM
- sym_pixel  in  1  font ROM response, same cycle
- out_valid  out  1  output pixel strobe
- out_pixel  out  1  rendered pixel

Behaviour:
- Reset: one clock and rst_n, synchronous active-low, sampled on rising clk edge. While rst_n=0: out_valid=0, out_pixel=0, sym_x=0, sym_y=0, sym_code=0, busy=1, state=CLEAR, clear address=0.
- FSM: CLEAR -> RUN. CLEAR writes CLEAR_CODE to address 0..COLS*ROWS-1, one per cycle; enters RUN the cycle after the last write (COLS*ROWS cycles after reset release). busy=1 exactly in CLEAR. Reset asserted mid-sweep restarts at address 0.
- Writes: in RUN, wr_en writes wr_code to address wr_row*COLS+wr_col. wr_col>=COLS or wr_row>=ROWS: ignored. wr_en during CLEAR: ignored, not queued.
- Pipeline, latency 2. Stage 0 (cycle N): col=in_x>>log2(GLYPH_W), row=in_y>>log2(GLYPH_H); buffer read issued; glyph offsets (in_x mod GLYPH_W, in_y mod GLYPH_H), in-range flag and in_valid registered. Stage 1 (N+1): sym_code=buffer data, sym_x/sym_y=registered offsets, zero-extended to XY_BIT_DEPTH. At end of N+1: out_pixel <= sym_pixel AND in-range AND valid; out_valid <= registered valid. Result visible cycle N+2.
- Out-of-range cell (col>=COLS or row>=ROWS): out_pixel=0, out_valid still follows in_valid.
- During CLEAR: out_valid follows in_valid through the pipeline, out_pixel forced 0.
- Read/write collision on the same address in the same cycle: read-first; render sees old code, new code from next read.
- sym_* hold last values when in_valid=0; out_pixel=0 whenever out_valid=0.
- Buffer is single-clock RAM, registered read, one read + one write port (clear sweep shares the write port).

Optional Feature:
- Macro TEXT_LAYER_CURSOR_EN. Defined: adds ports cursor_col (in, 7) and cursor_row (in, 5), and a frame counter advancing on in_valid with in_x=0 and in_y=0. Cursor visible during counter bit 4 = 0, giving a 32-frame toggle period. Pixels in the cursor cell are inverted while visible; out-of-range cursor never shown; counter resets to 0, so cursor is visible after reset.
- Undefined: no cursor ports, no counter, no inversion.

Decomposition:
- Package text_layer_pkg: CLEAR_CODE, address-width function clog2, cell address width constant, FSM state encoding (CLEAR, RUN), BLINK_BIT=4.
- One sub-module: text_buffer_ram (simple dual-port, registered read-first read, parameterised depth/width). FSM and pipeline stay in the top.

Test Plan:
- Reset release, idle raster -> busy=1 for exactly 2400 cycles, then 0; every cell reads 8'h20; out_pixel=0 throughout.
- After clear, write code 8'h41 at col 0 row 0; stream x=0..7, y=0..15 -> sym_code=8'h41 with sym_x/sym_y equal to offsets one cycle after input; out_pixel matches model glyph two cycles after input.
- in_x=640 (col 80), y=0 with ROM pixel forced 1 -> out_valid=1, out_pixel=0.
- wr_en during CLEAR at col 5 row 5, code 8'h7F -> cell still 8'h20 after sweep.
- Same-cycle write 8'h42 and render read of cell (3,2) -> that pixel uses old code; next read uses 8'h42.
- rst_n low for 1 cycle at sweep address 1000 -> busy stays 1 for a full 2400 more cycles; with TEXT_LAYER_CURSOR_EN, cursor (1,1) pixels invert in frames 0-15, normal in frames 16-31.
